// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads over a req/ack
// handshake and buffers returned words in a prefetch FIFO for decode.
// A redirect reloads the PC, flushes the FIFO and discards any in-flight read.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  // Old read still outstanding after a redirect; its data is thrown away.
  localparam logic [1:0] StDrop = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     drop_addr_q, drop_addr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     data_q [FIFO_DEPTH];
  logic [31:0]     pc_q   [FIFO_DEPTH];

  logic        push;
  logic        pop;
  logic [31:0] redir_pc;

  assign redir_pc    = {redirect_pc[31:2], 2'b00};
  assign imem_req    = (state_q == StReq) || (state_q == StDrop);
  assign imem_addr   = (state_q == StDrop) ? drop_addr_q : fetch_pc_q;
  assign instr_valid = (count_q != '0);
  assign instr       = data_q[rd_ptr_q];
  assign instr_pc    = pc_q[rd_ptr_q];
  assign pc_plus4    = instr_pc + 32'd4;

  // Redirect wins over both FIFO operations.
  assign pop  = instr_valid && instr_ready && !redirect_valid;
  assign push = (state_q == StReq) && imem_ack && !redirect_valid;

  // FIFO pointer and occupancy update; flush on redirect.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Fetch FSM next state and PC sequencing.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    case (state_q)
      StIdle: begin
        if (redirect_valid) begin
          fetch_pc_d = redir_pc;
          state_d    = StReq;
        end else if (count_d < DepthCnt) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (redirect_valid) begin
          fetch_pc_d = redir_pc;
          if (!imem_ack) begin
            // The request must stay up with its address until acked.
            drop_addr_d = fetch_pc_q;
            state_d     = StDrop;
          end
        end else begin
          if (imem_ack) fetch_pc_d = fetch_pc_q + 32'd4;
          // Only request again when the next push is guaranteed a slot.
          if (count_d >= DepthCnt) state_d = StIdle;
        end
      end
      StDrop: begin
        if (redirect_valid) fetch_pc_d = redir_pc;
        if (imem_ack) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage: instruction word and its PC per entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr_q] <= imem_rdata;
      pc_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by a
// randomized run checked against a PC-sequence / handshake reference model.
module tb_instr_fetch_unit;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  wire  [31:0] imem_rdata = mem_word(imem_addr);
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;

  int total = 0;
  int bad   = 0;

  instr_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_ready   (instr_ready),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .pc_plus4      (pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  logic [31:0] exp_pc;
  logic [31:0] prev_addr;
  logic        prev_req;
  logic        prev_ack;
  logic        exp_empty;
  int          acks;

  initial begin
    reset          = 1'b0;
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    #1;
    // Reset values
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_plus4", pc_plus4, 32'h4);

    // Zero-wait memory, decode always ready
    do_reset();
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    step();
    chk("t1_req_c1", {31'd0, imem_req}, 32'd1);
    chk("t1_valid_c1", {31'd0, instr_valid}, 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t1_valid", {31'd0, instr_valid}, 32'd1);
      chk("t1_pc", instr_pc, 32'(4 * i));
      chk("t1_instr", instr, mem_word(32'(4 * i)));
      step();
    end

    // Backpressure fills the FIFO, then drains and resumes
    do_reset();
    imem_ack = 1'b1;
    acks     = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (imem_req) acks++;
    end
    chk("t2_acks", 32'(acks), 32'd4);
    chk("t2_req_off", {31'd0, imem_req}, 32'd0);
    chk("t2_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_drain_valid", {31'd0, instr_valid}, 32'd1);
      chk("t2_drain_pc", instr_pc, 32'(4 * i));
      step();
    end

    // Slow memory, redirect while the read is outstanding
    do_reset();
    instr_ready = 1'b1;
    step();
    chk("t3_addr_c1", imem_addr, 32'h0);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("t3_req_held", {31'd0, imem_req}, 32'd1);
    chk("t3_addr_held", imem_addr, 32'h0);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("t3_addr_new", imem_addr, 32'h100);
    chk("t3_dropped", {31'd0, instr_valid}, 32'd0);
    step();
    step();
    chk("t3_still_empty", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("t3_valid", {31'd0, instr_valid}, 32'd1);
    chk("t3_pc", instr_pc, 32'h100);
    chk("t3_instr", instr, mem_word(32'h100));

    // Redirect coinciding with ack and pop, then wrap-around redirect
    do_reset();
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    step();
    step();
    chk("t4_pre_pc", instr_pc, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("t4_empty", {31'd0, instr_valid}, 32'd0);
    chk("t4_addr", imem_addr, 32'h40);
    step();
    chk("t4_valid", {31'd0, instr_valid}, 32'd1);
    chk("t4_pc", instr_pc, 32'h40);
    chk("t4_instr", instr, mem_word(32'h40));
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    chk("t5_empty", {31'd0, instr_valid}, 32'd0);
    step();
    chk("t5_pc0", instr_pc, 32'hFFFF_FFF8);
    chk("t5_p4_0", pc_plus4, 32'hFFFF_FFFC);
    step();
    chk("t5_pc1", instr_pc, 32'hFFFF_FFFC);
    chk("t5_p4_1", pc_plus4, 32'h0);
    step();
    chk("t5_pc2", instr_pc, 32'h0);
    chk("t5_instr2", instr, mem_word(32'h0));

    // Asynchronous reset in the middle of a request with two entries queued
    do_reset();
    imem_ack = 1'b1;
    step();
    step();
    step();
    chk("t6_pre_req", {31'd0, imem_req}, 32'd1);
    chk("t6_pre_valid", {31'd0, instr_valid}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_req", {31'd0, imem_req}, 32'd0);
    chk("t6_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_pc", instr_pc, 32'h0);

    // Randomized run against a delivery-order / handshake model
    do_reset();
    exp_pc    = 32'h0;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = '0;
    exp_empty = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (prev_req && !prev_ack) begin
        chk("rnd_req_kept", {31'd0, imem_req}, 32'd1);
        chk("rnd_addr_stable", imem_addr, prev_addr);
      end
      if (exp_empty) chk("rnd_flush_empty", {31'd0, instr_valid}, 32'd0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      imem_ack       = imem_req && ($urandom_range(0, 1) == 1);
      if ((i % 1000) < 400) instr_ready = ($urandom_range(0, 3) == 0);
      else                  instr_ready = ($urandom_range(0, 3) != 0);
      if (instr_valid && instr_ready && !redirect_valid) begin
        chk("rnd_pc", instr_pc, exp_pc);
        chk("rnd_instr", instr, mem_word(exp_pc));
        chk("rnd_plus4", pc_plus4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
      exp_empty = redirect_valid;
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
